// File: rtl/barrel_arb_pkg.sv
`default_nettype none
// ============================================================================
// barrel_arb_pkg : shared widths, state encoding and clog2 helper
// Revision 1.0
// ============================================================================
package barrel_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Minimum of 1 so a two-requester build still gets a 1-bit index.
  function automatic int arb_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// barrel_shifter : 8-bit logical left shift, zero fill
// Revision 1.0
// ============================================================================
module barrel_shifter (
  input  logic [7:0] x,
  input  logic [2:0] shamt,
  output logic [7:0] y
);

  assign y = x << shamt;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin pick of the first valid requester at or above rr_ptr
// Revision 1.0
// ============================================================================
module rr_arbiter
  import barrel_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   rr_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !grant_valid && req_valid[IDW'(idx)]) begin
        grant[IDW'(idx)] = 1'b1;
        grant_idx        = IDW'(idx);
        grant_valid      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/barrel_arbiter.sv
`default_nettype none
// ============================================================================
// barrel_arbiter : shares one barrel_shifter among N_REQ requesters with a
// one-entry tagged result register. Optional BARREL_ARB_STATS_EN adds stat_count.
// Revision 1.0
// ============================================================================
module barrel_arbiter
  import barrel_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = arb_clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*SHAMT_W-1:0] req_shamt,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready
`ifdef BARREL_ARB_STATS_EN
  ,
  output logic [15:0]              stat_count
`endif
);

  arb_state_e          state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]      out_id_q, out_id_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;

  logic                can_accept;
  logic [N_REQ-1:0]    grant;
  logic [IDW-1:0]      grant_idx;
  logic                grant_valid;
  logic [DATA_W-1:0]   sh_x;
  logic [SHAMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0]   sh_y;

  // Gating with rst keeps every ready low while reset is applied.
  assign can_accept = ((state_q == EMPTY) || out_ready) && !rst;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_arbiter (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .en          (can_accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;

  always_comb begin
    sh_x   = '0;
    sh_amt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sh_x   = req_data[i*DATA_W +: DATA_W];
        sh_amt = req_shamt[i*SHAMT_W +: SHAMT_W];
      end
    end
  end

  barrel_shifter u_barrel_shifter (
    .x     (sh_x),
    .shamt (sh_amt),
    .y     (sh_y)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_valid) begin
      state_d    = FULL;
      out_data_d = sh_y;
      out_id_d   = grant_idx;
      rr_ptr_d   = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef BARREL_ARB_STATS_EN
  logic [15:0] stat_count_q, stat_count_d;

  always_comb begin
    stat_count_d = stat_count_q;
    if (grant_valid && stat_count_q != 16'hFFFF) stat_count_d = stat_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stat_count_q <= '0;
    else     stat_count_q <= stat_count_d;
  end

  assign stat_count = stat_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/barrel_arbiter.md
# barrel_arbiter

Round-robin arbiter that shares one combinational `barrel_shifter` (8-bit data, 3-bit shift amount) among `N_REQ` requesters. Accepts one request per cycle via valid/ready, shifts it, and holds the result in a one-entry output register tagged with the requester index. It sits between the requesting datapath units and the single shifter instance, replacing direct per-unit shifter copies.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of requester index, equal to clog2(`N_REQ`).
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, `N_REQ` bits: per-requester request valid.
- `req_data` input, `N_REQ*8` bits: operand x; requester i occupies bits [8i+7:8i].
- `req_shamt` input, `N_REQ*3` bits: shift amount; requester i occupies bits [3i+2:3i].
- `req_ready` output, `N_REQ` bits: one-hot or zero; a request is accepted on a rising edge when valid and ready are both high.
- `out_valid` output, 1 bit: result register holds a result.
- `out_data` output, 8 bits: shifted result.
- `out_id` output, `IDW` bits: index of the requester that produced `out_data`.
- `out_ready` input, 1 bit: consumer takes the result.
- `stat_count` output, 16 bits: present only with `BARREL_ARB_STATS_EN`.

## Operation
- Shift function is the `barrel_shifter`: logical left shift of x by shamt, zero fill, 8-bit result (x=8'h81, shamt=1 -> 8'h02).
- Two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_accept` = EMPTY, or FULL with `out_ready`=1.
- Grant: when `can_accept` holds, choose the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping from `N_REQ`-1 to 0. Assert `req_ready` only for that index. With no valid requester or no `can_accept`, `req_ready` is all zero.
- Accept: mux the granted requester's data/shamt into the shifter. Register the result into `out_data`, the index into `out_id`, set FULL, and set `rr_ptr` = granted+1 mod `N_REQ`.
- FULL with `out_ready`=1 and no accept: go to EMPTY. `out_data`/`out_id` keep their values.
- FULL with `out_ready`=0: hold all outputs stable. No `req_ready` is asserted.
- Drain and accept in the same cycle: the new result replaces the old one and the state stays FULL. This gives sustained throughput of 1 per cycle.
- `rr_ptr` advances only on accept, never on idle cycles.
- Requesters may drop `req_valid` before being granted. A later request is arbitrated fresh.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `out_id`=0, `rr_ptr`=0 (requester 0 has highest priority), `stat_count`=0. `req_ready` is all zero during reset.
- Reset in FULL discards the held result.
- Latency: a request accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `rr_ptr`. No path from `req_data`/`req_shamt` to any ready.
- Worst-case wait for a continuously valid requester is `N_REQ`-1 accepts.

## Configuration
- `BARREL_ARB_STATS_EN` defined: `stat_count` port exists. It increments on each accept, saturates at 16'hFFFF, and clears on `rst`.
- `BARREL_ARB_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `barrel_arb_pkg`: data width constant 8, shift width constant 3, state enum {EMPTY, FULL}, and a clog2 helper for `IDW`.
- Sub-module `rr_arbiter`: takes `req_valid`, `rr_ptr` and an enable; returns a one-hot grant plus the encoded index.
- Reuse the existing `barrel_shifter` unchanged as a single instance.

## Test plan
- Reset then single request: req 2 with x=8'h03, shamt=2 -> `req_ready`=4'b0100; next cycle `out_valid`=1, `out_data`=8'h0C, `out_id`=2.
- All four requesters valid, `out_ready`=1 held -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
- Backpressure: FULL with `out_ready`=0 for 3 cycles -> `out_data`/`out_id` stable, `req_ready`=0; then `out_ready`=1 -> the next grant occurs that same cycle.
- Boundary shifts: x=8'hFF shamt=7 -> 8'h80; x=8'h81 shamt=0 -> 8'h81.
- `rst` asserted while FULL with requesters pending -> next cycle `out_valid`=0, and the first grant goes to requester 0.
- With `BARREL_ARB_STATS_EN`: 5 accepts -> `stat_count`=5. Preload to 16'hFFFE, then 3 accepts -> `stat_count`=16'hFFFF.
